// File: rtl/seq_detect_param_if.sv
// Configuration, serial data and status bundle for seq_detect_param.
// The master drives config and data; the slave (detector) drives status.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               cnt_clr;
    logic               flag;
    logic [CNT_W-1:0]   match_cnt;
    logic [LEN_W-1:0]   fill;

    modport master (
        output cfg_load,
        output cfg_pattern,
        output cfg_len,
        output cfg_overlap,
        output din_valid,
        output din,
        output cnt_clr,
        input  flag,
        input  match_cnt,
        input  fill
    );

    modport slave (
        input  cfg_load,
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_overlap,
        input  din_valid,
        input  din,
        input  cnt_clr,
        output flag,
        output match_cnt,
        output fill
    );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered match pulse and saturating match counter.
module seq_detect_param #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_detect_param_if.slave sd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0]   MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(8);
    localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(8'h55);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamp;
    logic               sample;
    logic               full;
    logic               hit;
    logic               drop;

    assign sample   = sd.din_valid & ~sd.cfg_load;
    assign hist_nxt = {hist_q[MAX_LEN-2:0], sd.din};
    assign fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    assign full     = (len_q != '0) && (fill_inc == len_q);

    assign len_clamp = (sd.cfg_len > MAX_L) ? MAX_L : sd.cfg_len;

    // Only the low L history bits take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hit  = sample && full &&
                  (((hist_nxt ^ pat_q) & mask) == '0);
    assign drop = hit && !ovl_q;

    always_comb begin
        cnt_d = cnt_q;
        if (sd.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        flag_d  = 1'b0;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;

        if (sd.cfg_load) begin
            pat_d   = sd.cfg_pattern;
            len_d   = len_clamp;
            ovl_d   = sd.cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = IDLE;
        end else if (sample) begin
            hist_d = hist_nxt;
            fill_d = drop ? '0 : fill_inc;
            flag_d = hit;
            unique case (state_q)
                IDLE: begin
                    if (fill_d != '0) begin
                        state_d = full ? ARMED : FILLING;
                    end
                end
                FILLING: begin
                    if (full) begin
                        state_d = drop ? IDLE : ARMED;
                    end
                end
                ARMED: begin
                    if (drop) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            pat_q   <= PAT_RST;
            len_q   <= LEN_RST;
            ovl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
        end
    end

    assign sd.flag      = flag_q;
    assign sd.match_cnt = cnt_q;
    assign sd.fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and random stimulus for seq_detect_param against a
// bit-queue reference model; two counter widths share one stream.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst_n;

    seq_detect_param_if #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8)) sd1 ();
    seq_detect_param_if #(.MAX_LEN(16), .LEN_W(5), .CNT_W(2)) sd2 ();

    seq_detect_param #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sd    (sd1)
    );

    seq_detect_param #(.MAX_LEN(16), .LEN_W(5), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .sd    (sd2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stepn = 0;

    // reference model state
    bit [15:0] m_pat;
    int        m_len;
    bit        m_ovl;
    int        m_fill;
    int        m_cnt1;
    int        m_cnt2;
    bit        m_flag;
    bit        hist[$];

    task automatic model_reset();
        m_pat  = 16'h0055;
        m_len  = 8;
        m_ovl  = 1'b1;
        m_fill = 0;
        m_cnt1 = 0;
        m_cnt2 = 0;
        m_flag = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge(input bit ld, input logic [15:0] p,
                              input logic [4:0] l, input bit ov,
                              input bit v, input bit d, input bit clr);
        bit ok;
        m_flag = 1'b0;
        if (ld) begin
            m_pat  = p;
            m_len  = (int'(l) > 16) ? 16 : int'(l);
            m_ovl  = ov;
            m_fill = 0;
            hist.delete();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 16) hist.delete(0);
            m_fill = (m_fill + 1 > m_len) ? m_len : m_fill + 1;
            if (m_len != 0 && m_fill == m_len) begin
                ok = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (hist[hist.size() - 1 - i] != m_pat[i]) ok = 1'b0;
                end
                if (ok) begin
                    m_flag = 1'b1;
                    if (m_cnt1 < 255) m_cnt1++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!m_ovl) m_fill = 0;
                end
            end
        end
        if (clr) begin
            m_cnt1 = 0;
            m_cnt2 = 0;
        end
    endtask

    task automatic drive(input bit ld, input logic [15:0] p,
                         input logic [4:0] l, input bit ov,
                         input bit v, input bit d, input bit clr);
        sd1.cfg_load = ld;  sd2.cfg_load = ld;
        sd1.cfg_pattern = p; sd2.cfg_pattern = p;
        sd1.cfg_len = l;     sd2.cfg_len = l;
        sd1.cfg_overlap = ov; sd2.cfg_overlap = ov;
        sd1.din_valid = v;   sd2.din_valid = v;
        sd1.din = d;         sd2.din = d;
        sd1.cnt_clr = clr;   sd2.cnt_clr = clr;
    endtask

    task automatic check_all(input string tag);
        tests++;
        assert (sd1.flag === m_flag) else begin
            fails++;
            $error("FAIL %s flag step=%0d got=%b exp=%b",
                   tag, stepn, sd1.flag, m_flag);
        end
        tests++;
        assert (sd1.fill === 5'(m_fill)) else begin
            fails++;
            $error("FAIL %s fill step=%0d got=%0d exp=%0d",
                   tag, stepn, sd1.fill, m_fill);
        end
        tests++;
        assert (sd1.match_cnt === 8'(m_cnt1)) else begin
            fails++;
            $error("FAIL %s cnt8 step=%0d got=%0d exp=%0d",
                   tag, stepn, sd1.match_cnt, m_cnt1);
        end
        tests++;
        assert (sd2.match_cnt === 2'(m_cnt2)) else begin
            fails++;
            $error("FAIL %s cnt2 step=%0d got=%0d exp=%0d",
                   tag, stepn, sd2.match_cnt, m_cnt2);
        end
        tests++;
        assert (sd2.flag === m_flag) else begin
            fails++;
            $error("FAIL %s flag2 step=%0d got=%b exp=%b",
                   tag, stepn, sd2.flag, m_flag);
        end
    endtask

    task automatic step(input string tag, input bit ld,
                        input logic [15:0] p, input logic [4:0] l,
                        input bit ov, input bit v, input bit d,
                        input bit clr);
        @(negedge clk);
        drive(ld, p, l, ov, v, d, clr);
        @(posedge clk);
        model_edge(ld, p, l, ov, v, d, clr);
        #1;
        check_all(tag);
        stepn++;
    endtask

    task automatic bitin(input string tag, input bit d);
        step(tag, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic load(input string tag, input logic [15:0] p,
                        input logic [4:0] l, input bit ov);
        step(tag, 1'b1, p, l, ov, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear(input string tag);
        step(tag, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  s8;
        logic [6:0]  s7;
        logic [15:0] rp;
        logic [4:0]  rl;
        bit          seen;

        rst_n = 1'b0;
        drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // legacy default pattern, then overlapping second match
        s8 = 8'h55;
        for (int i = 7; i >= 0; i--) bitin("legacy", s8[i]);
        bitin("legacy_ovl", 1'b0);
        bitin("legacy_ovl", 1'b1);

        // 1011 non-overlap, then overlap
        s7 = 7'b1011011;
        load("ld_nov", 16'h000b, 5'd4, 1'b0);
        for (int i = 6; i >= 0; i--) bitin("nov", s7[i]);
        clear("clr");
        load("ld_ov", 16'h000b, 5'd4, 1'b1);
        for (int i = 6; i >= 0; i--) bitin("ov", s7[i]);

        // single-bit pattern drives 2-bit counter into saturation
        load("ld_one", 16'h0001, 5'd1, 1'b1);
        clear("clr");
        for (int i = 0; i < 5; i++) bitin("sat2", 1'b1);
        step("clr_wins", 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) bitin("sat8", 1'b1);

        // reset discards a partial match
        do_reset("rst_mid");
        for (int i = 7; i >= 1; i--) bitin("partial", s8[i]);
        do_reset("rst_mid2");
        bitin("after_rst", 1'b1);
        for (int i = 7; i >= 3; i--) bitin("refill", s8[i]);
        step("ld_drop", 1'b1, 16'h0055, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);

        // oversize length clamps to 16
        rp = 16'($urandom);
        load("ld_len20", rp, 5'd20, 1'b1);
        for (int i = 15; i >= 0; i--) bitin("len16", rp[i]);
        for (int i = 0; i < 20; i++) bitin("len16_rnd", 1'($urandom));

        // length 0 never fires
        load("ld_len0", 16'($urandom), 5'd0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bitin("len0", 1'($urandom));
            seen = seen | sd1.flag | sd2.flag;
        end
        tests++;
        assert (seen === 1'b0) else begin
            fails++;
            $error("FAIL len0_any_flag got=%b exp=0", seen);
        end

        // random configurations, gaps, clears and load-with-valid
        for (int k = 0; k < 16; k++) begin
            rl = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(1, 6));
            rp = 16'($urandom);
            step("rnd_ld", 1'b1, rp, rl, 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b0);
            for (int j = 0; j < 50; j++) begin
                step("rnd", 1'b0, 16'h0, 5'd0, 1'b0,
                     ($urandom_range(0, 3) != 0), 1'($urandom),
                     ($urandom_range(0, 40) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
